// File: rtl/traffic_sensor_model_if.sv
// Light/arrival inputs and queue status outputs of the street-side sensor model.
// Signal names are from the sensor's point of view.
interface traffic_sensor_model_if #(
    parameter int CW = 4
);
    logic [1:0]    i_LA;
    logic [1:0]    i_LB;
    logic          i_arrive_A;
    logic          i_arrive_B;
    logic          o_TA;
    logic          o_TB;
    logic [CW-1:0] o_cnt_A;
    logic [CW-1:0] o_cnt_B;
    logic          o_pass_A;
    logic          o_pass_B;
    logic [1:0]    o_ovf;
    logic [1:0]    o_err;

    modport master (
        output i_LA, i_LB, i_arrive_A, i_arrive_B,
        input  o_TA, o_TB, o_cnt_A, o_cnt_B,
        input  o_pass_A, o_pass_B, o_ovf, o_err
    );

    modport slave (
        input  i_LA, i_LB, i_arrive_A, i_arrive_B,
        output o_TA, o_TB, o_cnt_A, o_cnt_B,
        output o_pass_A, o_pass_B, o_ovf, o_err
    );
endinterface

// File: rtl/traffic_sensor_model.sv
// Per-street vehicle queues drained while GREEN, feeding TA/TB back to the
// light controller, plus a sticky monitor for unsafe light combinations.
module traffic_sensor_model #(
    parameter int QDEPTH     = 15,
    parameter int CW         = 4,
    parameter int DEPART_CYC = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    traffic_sensor_model_if.slave bus
);
    localparam int TW = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
    localparam logic [TW-1:0] TLAST = TW'(DEPART_CYC - 1);
    localparam logic [CW-1:0] QMAX  = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_FLOW  = 2'd2
    } state_t;

    state_t        st_q  [2];
    state_t        st_d  [2];
    logic [TW-1:0] tmr_q [2];
    logic [TW-1:0] tmr_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    pass_q, pass_d;
    logic [1:0]    ovf_q, ovf_d;
    logic [1:0]    err_q, err_d;

    logic [1:0]    lt [2];
    logic [1:0]    arr;
    logic [1:0]    green;
    logic [1:0]    dep;

    assign lt[0] = bus.i_LA;
    assign lt[1] = bus.i_LB;
    assign arr   = {bus.i_arrive_B, bus.i_arrive_A};

    always_comb begin
        err_d  = err_q;
        ovf_d  = ovf_q;
        pass_d = '0;
        green  = '0;
        dep    = '0;
        if (bus.i_LA != 2'd2 && bus.i_LB != 2'd2) err_d[0] = 1'b1;
        if (bus.i_LA == 2'd3 || bus.i_LB == 2'd3) err_d[1] = 1'b1;

        for (int x = 0; x < 2; x++) begin
            green[x]  = (lt[x] == 2'd0);
            dep[x]    = (st_q[x] == S_FLOW) && green[x]
                        && (tmr_q[x] == TLAST);
            st_d[x]   = st_q[x];
            tmr_d[x]  = tmr_q[x];
            cnt_d[x]  = cnt_q[x];
            pass_d[x] = dep[x];

            unique case (st_q[x])
                S_EMPTY: begin
                    tmr_d[x] = '0;
                    if (arr[x]) st_d[x] = green[x] ? S_FLOW : S_WAIT;
                end
                S_WAIT: begin
                    tmr_d[x] = '0;
                    if (green[x]) st_d[x] = S_FLOW;
                end
                S_FLOW: begin
                    if (!green[x]) begin
                        st_d[x]  = S_WAIT;
                        tmr_d[x] = '0;
                    end else if (dep[x]) begin
                        tmr_d[x] = '0;
                        if (cnt_q[x] == CW'(1) && !arr[x])
                            st_d[x] = S_EMPTY;
                    end else begin
                        tmr_d[x] = tmr_q[x] + TW'(1);
                    end
                end
                default: begin
                    st_d[x]  = S_EMPTY;
                    tmr_d[x] = '0;
                end
            endcase

            // Arrival and departure together leave the count unchanged.
            if (arr[x] && !dep[x]) begin
                if (cnt_q[x] == QMAX) ovf_d[x] = 1'b1;
                else                  cnt_d[x] = cnt_q[x] + CW'(1);
            end else if (!arr[x] && dep[x]) begin
                cnt_d[x] = cnt_q[x] - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int x = 0; x < 2; x++) begin
                st_q[x]  <= S_EMPTY;
                tmr_q[x] <= '0;
                cnt_q[x] <= '0;
            end
            pass_q <= '0;
            ovf_q  <= '0;
            err_q  <= '0;
        end else begin
            for (int x = 0; x < 2; x++) begin
                st_q[x]  <= st_d[x];
                tmr_q[x] <= tmr_d[x];
                cnt_q[x] <= cnt_d[x];
            end
            pass_q <= pass_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
        end
    end

    assign bus.o_TA     = |cnt_q[0];
    assign bus.o_TB     = |cnt_q[1];
    assign bus.o_cnt_A  = cnt_q[0];
    assign bus.o_cnt_B  = cnt_q[1];
    assign bus.o_pass_A = pass_q[0];
    assign bus.o_pass_B = pass_q[1];
    assign bus.o_ovf    = ovf_q;
    assign bus.o_err    = err_q;
endmodule

// File: tb/tb_traffic_sensor_model.sv
// Closed-form street queue model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_traffic_sensor_model;
    localparam int Q = 15;
    localparam int D = 2;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    traffic_sensor_model_if #(.CW(4)) bus ();

    traffic_sensor_model #(
        .QDEPTH(Q), .CW(4), .DEPART_CYC(D)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // A street is "flowing" once it has cars and has seen a GREEN cycle;
    // a car leaves after D consecutive GREEN cycles of flowing.
    int m_cnt  [2];
    int m_run  [2];
    bit m_flow [2];
    bit m_pass [2];
    bit [1:0] m_ovf;
    bit [1:0] m_err;
    bit mv;

    initial mv = 1'b0;

    always @(posedge clk) begin
        int l [2];
        bit a [2];
        bit g;
        bit dp;
        if (rst) begin
            for (int x = 0; x < 2; x++) begin
                m_cnt[x]  = 0;
                m_run[x]  = 0;
                m_flow[x] = 0;
                m_pass[x] = 0;
            end
            m_ovf = '0;
            m_err = '0;
            mv    = 1'b1;
        end else begin
            l[0] = int'(bus.i_LA);
            l[1] = int'(bus.i_LB);
            a[0] = bus.i_arrive_A;
            a[1] = bus.i_arrive_B;
            if (l[0] != 2 && l[1] != 2) m_err[0] = 1'b1;
            if (l[0] == 3 || l[1] == 3) m_err[1] = 1'b1;
            for (int x = 0; x < 2; x++) begin
                g  = (l[x] == 0);
                dp = 1'b0;
                if (m_flow[x] && g) begin
                    m_run[x]++;
                    if (m_run[x] == D) begin
                        dp = 1'b1;
                        m_run[x] = 0;
                    end
                end else begin
                    m_run[x] = 0;
                end
                if (a[x]) begin
                    if (m_cnt[x] == Q && !dp) m_ovf[x] = 1'b1;
                    else m_cnt[x]++;
                end
                if (dp) m_cnt[x]--;
                m_pass[x] = dp;
                m_flow[x] = (m_cnt[x] > 0) && g;
            end
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("m_cnt_A",  int'(bus.o_cnt_A),  m_cnt[0]);
            chk("m_cnt_B",  int'(bus.o_cnt_B),  m_cnt[1]);
            chk("m_TA",     int'(bus.o_TA),     int'(m_cnt[0] != 0));
            chk("m_TB",     int'(bus.o_TB),     int'(m_cnt[1] != 0));
            chk("m_pass_A", int'(bus.o_pass_A), int'(m_pass[0]));
            chk("m_pass_B", int'(bus.o_pass_B), int'(m_pass[1]));
            chk("m_ovf",    int'(bus.o_ovf),    int'(m_ovf));
            chk("m_err",    int'(bus.o_err),    int'(m_err));
        end
    end

    // Inputs change at a negedge; one rising edge passes; checks follow.
    task automatic step(input logic [1:0] la, input logic [1:0] lb,
                        input logic aa, input logic ab);
        bus.i_LA       = la;
        bus.i_LB       = lb;
        bus.i_arrive_A = aa;
        bus.i_arrive_B = ab;
        @(negedge clk);
    endtask

    int exp_pass [7] = '{0, 0, 1, 0, 1, 0, 1};
    int exp_cnt  [7] = '{3, 3, 2, 2, 1, 1, 0};

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rst = 1'b0;
        chk("rst_cnt_A", int'(bus.o_cnt_A), 0);
        chk("rst_TB",    int'(bus.o_TB),    0);
        chk("rst_err",   int'(bus.o_err),   0);

        for (int k = 1; k <= 3; k++) begin
            step(2'd2, 2'd0, 1'b1, 1'b0);
            chk("fill_cnt",  int'(bus.o_cnt_A),  k);
            chk("fill_TA",   int'(bus.o_TA),     1);
            chk("fill_pass", int'(bus.o_pass_A), 0);
        end

        for (int k = 0; k < 7; k++) begin
            step(2'd0, 2'd2, 1'b0, 1'b0);
            chk("drain_pass", int'(bus.o_pass_A), exp_pass[k]);
            chk("drain_cnt",  int'(bus.o_cnt_A),  exp_cnt[k]);
        end
        chk("drain_TA", int'(bus.o_TA), 0);

        for (int k = 0; k < 17; k++) step(2'd0, 2'd2, 1'b0, 1'b1);
        chk("ovf_cnt", int'(bus.o_cnt_B), 15);
        chk("ovf_flag", int'(bus.o_ovf), 2);
        for (int k = 0; k < 10; k++) step(2'd0, 2'd2, 1'b0, 1'b0);
        chk("ovf_sticky", int'(bus.o_ovf), 2);

        for (int k = 0; k < 6; k++) step(2'd2, 2'd2, 1'b1, 1'b0);
        chk("sim_pre", int'(bus.o_cnt_A), 6);
        for (int k = 0; k < 3; k++) step(2'd0, 2'd2, 1'b0, 1'b0);
        chk("sim_cnt5", int'(bus.o_cnt_A), 5);
        step(2'd0, 2'd2, 1'b0, 1'b0);
        step(2'd0, 2'd2, 1'b1, 1'b0);
        chk("sim_cnt",  int'(bus.o_cnt_A),  5);
        chk("sim_pass", int'(bus.o_pass_A), 1);
        step(2'd0, 2'd2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(2'd1, 2'd2, 1'b0, 1'b0);
            chk("yel_pass", int'(bus.o_pass_A), 0);
            chk("yel_cnt",  int'(bus.o_cnt_A),  5);
        end
        step(2'd0, 2'd2, 1'b0, 1'b0);
        step(2'd0, 2'd2, 1'b0, 1'b0);
        chk("grn_pass1", int'(bus.o_pass_A), 0);
        step(2'd0, 2'd2, 1'b0, 1'b0);
        chk("grn_pass2", int'(bus.o_pass_A), 1);
        chk("grn_cnt",   int'(bus.o_cnt_A),  4);

        step(2'd0, 2'd1, 1'b0, 1'b0);
        chk("err_conf", int'(bus.o_err), 1);
        step(2'd0, 2'd2, 1'b0, 1'b0);
        step(2'd0, 2'd2, 1'b0, 1'b0);
        chk("err_hold", int'(bus.o_err), 1);
        step(2'd3, 2'd2, 1'b0, 1'b0);
        chk("err_ill", int'(bus.o_err), 3);

        rst = 1'b1;
        step(2'd0, 2'd2, 1'b1, 1'b1);
        rst = 1'b0;
        chk("rst2_err",   int'(bus.o_err),   0);
        chk("rst2_ovf",   int'(bus.o_ovf),   0);
        chk("rst2_cnt_B", int'(bus.o_cnt_B), 0);
        step(2'd2, 2'd2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
